// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combinational sweep controller.
package comb_sweep_pkg;

    localparam int unsigned NUM_IMPL = 4;
    localparam int unsigned NUM_VEC  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/comb_sweep_cmp.sv
// All-equal check across the implementation outputs: flags a mismatch when they disagree.
module comb_sweep_cmp
    import comb_sweep_pkg::*;
(
    input  logic [NUM_IMPL-1:0] y,
    output logic                mismatch
);

    always_comb begin
        mismatch = !((y == '0) || (y == '1));
    end

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive 4-input sweep comparing four Y(A,B,C,D) implementations.
// Optional truth-table capture output is enabled with COMB_SWEEP_TRUTH_EN.
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_IMPL-1:0] y,
    output logic [3:0]          abcd,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [4:0]          mism_cnt,
    output logic [3:0]          first_fail
`ifdef COMB_SWEEP_TRUTH_EN
    ,
    output logic [NUM_VEC-1:0]  truth
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] VEC_LAST    = 4'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [4:0] mism_q, mism_d;
    logic [3:0] ff_q, ff_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    comb_sweep_cmp u_cmp (
        .y        (y),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            settle_q <= '0;
            mism_q   <= '0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            mism_q   <= mism_d;
            ff_q     <= ff_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        mism_d   = mism_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StWait;
                    vec_d    = '0;
                    settle_d = '0;
                    mism_d   = '0;
                    ff_d     = '0;
                    pass_d   = 1'b0;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else begin
                    settle_d = settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                // Abort beats a same-cycle mismatch: nothing is counted.
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        mism_d = mism_q + 5'd1;
                        if (mism_q == 5'd0) begin
                            ff_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = StDone;
                        // Loaded on entry so pass is already valid during the done pulse.
                        pass_d  = (mism_q == 5'd0) && !mismatch;
                    end else begin
                        state_d  = StWait;
                        vec_d    = vec_q + 4'd1;
                        settle_d = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        abcd       = (state_q == StIdle) ? 4'd0 : vec_q;
        busy       = (state_q == StWait) || (state_q == StCheck);
        done       = (state_q == StDone);
        pass       = pass_q;
        mism_cnt   = mism_q;
        first_fail = ff_q;
    end

`ifdef COMB_SWEEP_TRUTH_EN
    logic [NUM_VEC-1:0] truth_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            truth_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            truth_q <= '0;
        end else if (state_q == StCheck) begin
            truth_q[vec_q] <= y[0];
        end
    end

    always_comb begin
        truth = truth_q;
    end
`endif

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed bench for comb_sweep_ctrl with a cycle-index model checked every cycle.
module tb_comb_sweep_ctrl;

    localparam int unsigned SETTLE = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  y;
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mism_cnt;
    logic [3:0]  first_fail;
`ifdef COMB_SWEEP_TRUTH_EN
    logic [15:0] truth;
`endif

    logic [15:0] fault_mask;
    int          errors;
    int          checks;
    bit          chk_en;

    comb_sweep_ctrl #(
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .y          (y),
        .abcd       (abcd),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .mism_cnt   (mism_cnt),
        .first_fail (first_fail)
`ifdef COMB_SWEEP_TRUTH_EN
        ,
        .truth      (truth)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Y = C & D on all four copies; y[3] flipped on faulted vectors.
    logic ref_y;
    always_comb begin
        ref_y = abcd[1] & abcd[0];
        y     = {ref_y ^ fault_mask[abcd], {3{ref_y}}};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a run of 16*(SETTLE+1) cycles indexed by m_k; the last
    // cycle of each vector's slot is its check cycle.
    bit          m_run;
    bit          m_done;
    int          m_k;
    int          m_mism;
    int          m_ff;
    bit          m_pass;
    logic [15:0] m_truth;

    always @(posedge clk) begin
        int v;
        int ph;
        if (rst) begin
            m_run = 0; m_done = 0; m_k = 0; m_mism = 0; m_ff = 0; m_pass = 0; m_truth = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_k = 0; m_mism = 0; m_ff = 0; m_pass = 0; m_truth = '0;
            end
        end else begin
            v  = m_k / (SETTLE + 1);
            ph = m_k % (SETTLE + 1);
            if (ph == SETTLE) m_truth[v] = ((v & 3) == 3);
            if (abort) begin
                m_run  = 0;
                m_pass = 0;
            end else begin
                if (ph == SETTLE) begin
                    if (fault_mask[v]) begin
                        if (m_mism == 0) m_ff = v;
                        m_mism++;
                    end
                    if (v == 15) begin
                        m_run  = 0;
                        m_done = 1;
                        m_pass = (m_mism == 0);
                    end
                end
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_abcd;
        if (chk_en) begin
            exp_abcd = m_done ? 4'hf : (m_run ? 4'(m_k / (SETTLE + 1)) : 4'h0);
            chk("model_abcd", 32'(abcd), 32'(exp_abcd));
            chk("model_busy", 32'(busy), 32'(m_run));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_pass", 32'(pass), 32'(m_pass));
            chk("model_mism_cnt", 32'(mism_cnt), 32'(m_mism));
            chk("model_first_fail", 32'(first_fail), 32'(m_ff));
`ifdef COMB_SWEEP_TRUTH_EN
            chk("model_truth", 32'(truth), 32'(m_truth));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n_at);
        n_at = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (done) begin
                n_at = n;
                break;
            end
        end
        if (n_at < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within 200 cycles, required a done pulse");
        end
    endtask

    task automatic wait_vec(input logic [3:0] v);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (abcd == v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL vec_timeout: abcd never reached %0d", v);
        end
    endtask

    initial begin
        int n_at;
        errors     = 0;
        checks     = 0;
        chk_en     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        fault_mask = 16'h0000;

        tick();
        chk_en = 1;
        chk("rst_abcd", 32'(abcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_mism_cnt", 32'(mism_cnt), 32'h0);
        chk("rst_first_fail", 32'(first_fail), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Clean sweep: done 49 cycles after start is accepted.
        start = 1'b1;
        wait_done(n_at);
        chk("clean_done_cycle", 32'(n_at), 32'd49);
        chk("clean_pass", 32'(pass), 32'h1);
        chk("clean_mism_cnt", 32'(mism_cnt), 32'h0);
        chk("clean_abcd_done", 32'(abcd), 32'hf);
`ifdef COMB_SWEEP_TRUTH_EN
        chk("truth_table", 32'(truth), 32'h8888);
`endif
        tick();
        chk("clean_idle_abcd", 32'(abcd), 32'h0);
        chk("clean_idle_pass_hold", 32'(pass), 32'h1);

        // y[3] corrupted at vectors 5 and 12.
        fault_mask = 16'h1020;
        start = 1'b1;
        wait_done(n_at);
        chk("two_fault_mism_cnt", 32'(mism_cnt), 32'd2);
        chk("two_fault_first_fail", 32'(first_fail), 32'd5);
        chk("two_fault_pass", 32'(pass), 32'h0);
        tick();

        // Only the last vector fails.
        fault_mask = 16'h8000;
        start = 1'b1;
        wait_done(n_at);
        chk("last_fault_mism_cnt", 32'(mism_cnt), 32'd1);
        chk("last_fault_first_fail", 32'(first_fail), 32'd15);
        chk("last_fault_pass", 32'(pass), 32'h0);
        tick();

        // Abort while sweeping vector 7.
        fault_mask = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(4'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_abcd", 32'(abcd), 32'h0);
        chk("abort_pass", 32'(pass), 32'h0);
        repeat (3) tick();
        start = 1'b1;
        wait_done(n_at);
        chk("post_abort_done_cycle", 32'(n_at), 32'd49);
        chk("post_abort_pass", 32'(pass), 32'h1);
        tick();

        // Abort coincides with the check of a mismatching vector 4.
        fault_mask = 16'h0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(4'd4);
        repeat (SETTLE) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_check_mism_cnt", 32'(mism_cnt), 32'h0);
        chk("abort_check_first_fail", 32'(first_fail), 32'h0);
        chk("abort_check_busy", 32'(busy), 32'h0);
        tick();

        // Reset mid-sweep with start held high throughout.
        fault_mask = 16'h0004;
        start = 1'b1;
        wait_vec(4'd9);
        chk("pre_rst_mism_cnt", 32'(mism_cnt), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_abcd", 32'(abcd), 32'h0);
        chk("mid_rst_mism_cnt", 32'(mism_cnt), 32'h0);
        chk("mid_rst_first_fail", 32'(first_fail), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_restart_busy", 32'(busy), 32'h1);
        chk("rst_restart_abcd", 32'(abcd), 32'h0);
        wait_done(n_at);
        chk("rst_restart_done_cycle", 32'(n_at), 32'd48);
        chk("rst_restart_mism_cnt", 32'(mism_cnt), 32'd1);
        chk("rst_restart_first_fail", 32'(first_fail), 32'd2);
        chk("rst_restart_pass", 32'(pass), 32'h0);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comb_sweep_ctrl.md
COMB_SWEEP_CTRL -- requirements
Module: comb_sweep_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE, default 2, giving the number of cycles a vector is held before its outputs are sampled; legal range 1..15.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port start, input, 1 bit: request for one exhaustive sweep; sampled only in IDLE.
REQ-005 SHALL provide port abort, input, 1 bit: cancels a running sweep.
REQ-006 SHALL provide port y, input, 4 bits: outputs of the four Y(A,B,C,D) implementations (str, dataflow, behavior, prim), bit i = implementation i.
REQ-007 SHALL provide port abcd, output, 4 bits: stimulus vector {A,B,C,D} driven to all four implementations.
REQ-008 SHALL provide port busy, output, 1 bit: high in WAIT and CHECK.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse at the end of a completed sweep.
REQ-010 SHALL provide port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-011 SHALL provide port mism_cnt, output, 5 bits: number of mismatching vectors, range 0..16.
REQ-012 SHALL provide port first_fail, output, 4 bits: first mismatching vector of the current or last sweep, 0 if none.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, CHECK and DONE.
REQ-014 IDLE with start=1 SHALL, on the next cycle, enter WAIT with vec=0, settle_cnt=0, mism_cnt=0, first_fail=0 and pass=0.
REQ-015 WAIT SHALL drive abcd=vec and increment settle_cnt, entering CHECK when settle_cnt==SETTLE-1, so each vector lasts exactly SETTLE+1 cycles.
REQ-016 CHECK SHALL flag a mismatch when y is neither 4'b0000 nor 4'b1111, incrementing mism_cnt and, on the first mismatch only, loading first_fail=vec.
REQ-017 CHECK with vec==15 SHALL go to DONE; otherwise it SHALL increment vec, clear settle_cnt and return to WAIT.
REQ-018 DONE SHALL assert done for exactly one cycle, set pass=(mism_cnt==0) including any mismatch found at vector 15, then return to IDLE.
REQ-019 A full sweep SHALL take 16*(SETTLE+1) cycles from the first WAIT cycle to DONE, i.e. 48 cycles for SETTLE=2.
REQ-020 abcd SHALL hold its last driven value in CHECK and DONE and SHALL be 0 in IDLE.
REQ-021 start SHALL be ignored outside IDLE, and start asserted in the DONE cycle SHALL NOT be acted on until IDLE.
REQ-022 abort in WAIT or CHECK SHALL return the FSM to IDLE on the next cycle with no done pulse and pass=0, leaving mism_cnt and first_fail frozen.
REQ-023 When abort and a CHECK mismatch occur in the same cycle, abort SHALL win and the mismatch SHALL NOT be counted.
REQ-024 mism_cnt, pass and first_fail SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-025 rst=1 SHALL force IDLE with abcd=0, busy=0, done=0, pass=0, mism_cnt=0, first_fail=0, vec=0 and settle_cnt=0.
REQ-026 rst SHALL take priority over start and abort.
REQ-027 rst asserted mid-sweep SHALL abort the sweep with no done pulse.

Configuration
REQ-028 With COMB_SWEEP_TRUTH_EN defined, the block SHALL add output truth, 16 bits, where bit vec is loaded from y[0] in each CHECK, truth is cleared on accepted start and on reset, and truth is held otherwise.
REQ-029 Without COMB_SWEEP_TRUTH_EN, the truth port and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package comb_sweep_pkg SHALL hold the FSM state enum, NUM_IMPL=4 and NUM_VEC=16.
REQ-031 A sub-module comb_sweep_cmp SHALL implement the combinational all-equal check of y producing a mismatch flag, and it SHALL be the only sub-module.

Verification
REQ-032 Bench SHALL cover: SETTLE=2, four matching instances, start pulse -> abcd steps 0..15, done at cycle 49 after start, pass=1, mism_cnt=0.
REQ-033 Bench SHALL cover: y[3] forced to invert at vectors 5 and 12 -> mism_cnt=2, first_fail=5, pass=0.
REQ-034 Bench SHALL cover: mismatch only at vector 15 -> mism_cnt=1, first_fail=15, pass=0 in the DONE cycle.
REQ-035 Bench SHALL cover: abort during vector 7 -> IDLE next cycle, no done, abcd=0, pass=0; a later start gives a clean full sweep.
REQ-036 Bench SHALL cover: rst mid-sweep plus start held high throughout -> all outputs reset, a new sweep begins one cycle after rst falls.
REQ-037 Bench SHALL cover: with COMB_SWEEP_TRUTH_EN defined and the reference function (Y = 1 for vectors 3, 7, 11, 15) -> truth=16'h8888.
